// File: rtl/ct_spsram_16384x128_arb.sv
// Zero-fill sequencer and two-port round-robin arbiter in front of the
// 16384x128 single-port SRAM macro (active-low CEN/GWEN/WEN controls).
module ct_spsram_16384x128_arb #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 128,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req0_vld,
  output logic                  req0_rdy,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_wr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  input  logic                  req1_vld,
  output logic                  req1_rdy,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_wr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  rsp0_vld,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;
  logic                  ptr, ptr_nxt;
  logic [ADDR_WIDTH-1:0] last_a;
  logic [DATA_WIDTH-1:0] last_d;
  logic                  gnt0, gnt1;

  // On contention the pointer picks the winner; a lone requester always wins.
  always_comb begin
    gnt0 = (state == ST_RUN) && req0_vld && (!req1_vld || !ptr);
    gnt1 = (state == ST_RUN) && req1_vld && (!req0_vld ||  ptr);
  end

  assign req0_rdy  = gnt0;
  assign req1_rdy  = gnt1;
  assign init_done = (state == ST_RUN);
  assign rsp_data  = sram_q;

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    ptr_nxt      = ptr;
    case (state)
      ST_IDLE: state_nxt = INIT_EN ? ST_INIT : ST_RUN;
      ST_INIT: begin
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == '1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (init_req) begin
          state_nxt    = ST_INIT;
          init_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (gnt0)      ptr_nxt = 1'b1;
    else if (gnt1) ptr_nxt = 1'b0;
  end

  // Address and data buses keep their last driven value while the macro is idle.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = last_a;
    sram_d    = last_d;
    if (state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt;
      sram_d    = '0;
    end else if (gnt0) begin
      sram_cen  = 1'b0;
      sram_gwen = ~req0_wr;
      sram_wen  = ~req0_wmask;
      sram_a    = req0_addr;
      sram_d    = req0_wdata;
    end else if (gnt1) begin
      sram_cen  = 1'b0;
      sram_gwen = ~req1_wr;
      sram_wen  = ~req1_wmask;
      sram_a    = req1_addr;
      sram_d    = req1_wdata;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state    <= ST_IDLE;
      init_cnt <= '0;
      ptr      <= 1'b0;
      rsp0_vld <= 1'b0;
      rsp1_vld <= 1'b0;
      last_a   <= '0;
      last_d   <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      ptr      <= ptr_nxt;
      rsp0_vld <= gnt0 && !req0_wr;
      rsp1_vld <= gnt1 && !req1_wr;
      if (!sram_cen) begin
        last_a <= sram_a;
        last_d <= sram_d;
      end
    end
  end

endmodule

// File: tb/tb_ct_spsram_16384x128_arb.sv
// Directed bench for ct_spsram_16384x128_arb with a behavioural SRAM macro.
module tb_ct_spsram_16384x128_arb;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 128;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [DW-1:0] ALL1 = '1;
  localparam logic [DW-1:0] MASK = {8'h00, {120{1'b1}}};

  logic          clk, rst, init_req, init_done;
  logic          req0_vld, req0_rdy, req0_wr, req1_vld, req1_rdy, req1_wr;
  logic [AW-1:0] req0_addr, req1_addr, sram_a;
  logic [DW-1:0] req0_wdata, req0_wmask, req1_wdata, req1_wmask;
  logic          rsp0_vld, rsp1_vld, sram_cen, sram_gwen;
  logic [DW-1:0] rsp_data, sram_d, sram_wen, sram_q;

  logic [DW-1:0] mem [DEPTH];
  logic          preload;
  int unsigned   n_chk, n_pass;

  ct_spsram_16384x128_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
    .forever_cpuclk(clk), .cpurst(rst), .init_req(init_req), .init_done(init_done),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_addr(req0_addr), .req0_wr(req0_wr),
    .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_addr(req1_addr), .req1_wr(req1_wr),
    .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
    .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld), .rsp_data(rsp_data),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_d(sram_d), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_q(sram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous macro: Q updates on the clock after a read; WEN bit 0 writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= {4{32'hA5A5_0000 | i}};
    end else if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_done"}, DW'(init_done), '0);
    chk({tag, "_rdy"},  DW'({req0_rdy, req1_rdy}), '0);
    chk({tag, "_rsp"},  DW'({rsp0_vld, rsp1_vld}), '0);
    chk({tag, "_cen"},  DW'({sram_cen, sram_gwen}), DW'(2'b11));
    chk({tag, "_wen"},  sram_wen, ALL1);
    chk({tag, "_a"},    DW'(sram_a), '0);
    chk({tag, "_d"},    sram_d, '0);
  endtask

  // Called in the first INIT cycle; returns in the first RUN cycle.
  task automatic fill();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      chk("fill_a", DW'(sram_a), DW'(i));
      chk("fill_ctl", DW'({req0_rdy, req1_rdy, sram_cen, sram_gwen, |sram_wen, |sram_d, init_done}), '0);
      tick();
    end
  endtask

  int unsigned gexp [9] = '{1, 1, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; preload = 1'b1; init_req = 1'b0;
    req0_vld = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
    req1_vld = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
    @(posedge clk);
    #1 preload = 1'b0;
    @(posedge clk);
    #1 chk_reset("rst");
    rst = 1'b0;
    #1 chk_reset("idle");

    // Partial fill, then reset in the middle of it
    tick();
    for (int unsigned i = 0; i < 100; i++) begin
      chk("pre_a", DW'(sram_a), DW'(i));
      tick();
    end
    chk("pre_a100", DW'(sram_a), DW'(100));
    rst = 1'b1;
    #1 chk_reset("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_reset("rel");

    // Full fill with both requesters pushing: no grant may leak through
    tick();
    req0_vld = 1'b1; req1_vld = 1'b1;
    fill();
    req0_vld = 1'b0; req1_vld = 1'b0;
    chk("done", DW'(init_done), DW'(1));
    chk("mem0", mem[0], '0);
    chk("mem5", mem[5], '0);
    chk("memlast", mem[DEPTH-1], '0);

    // Masked write then read-back on requester 0
    req0_vld = 1'b1; req0_wr = 1'b1; req0_addr = 14'h0005; req0_wdata = ALL1; req0_wmask = MASK;
    #1;
    chk("wr_rdy", DW'({req0_rdy, req1_rdy}), DW'(2'b10));
    chk("wr_ctl", DW'({sram_cen, sram_gwen}), '0);
    chk("wr_wen", sram_wen, ~MASK);
    chk("wr_a", DW'(sram_a), DW'(5));
    chk("wr_d", sram_d, ALL1);
    tick();
    req0_wr = 1'b0;
    #1;
    chk("rd_ctl", DW'({req0_rdy, sram_cen, sram_gwen}), DW'(3'b101));
    chk("wr_norsp", DW'({rsp0_vld, rsp1_vld}), '0);
    tick();
    req0_vld = 1'b0;
    #1;
    chk("rd_rsp", DW'({rsp0_vld, rsp1_vld}), DW'(2'b10));
    chk("rd_data", rsp_data, MASK);
    chk("idle_ctl", DW'({sram_cen, sram_gwen, &sram_wen}), DW'(3'b111));
    chk("hold_a", DW'(sram_a), DW'(5));

    // req1 alone three times, then both: grants 1,1,1,0,1,0,1,0,1
    req0_addr = 14'h0005; req1_addr = 14'h0006; req1_wr = 1'b0;
    for (int c = 0; c < 9; c++) begin
      req0_vld = (c >= 3);
      req1_vld = 1'b1;
      #1;
      chk("rr_rdy", DW'({req0_rdy, req1_rdy}), gexp[c] != 0 ? DW'(2'b01) : DW'(2'b10));
      chk("rr_a", DW'(sram_a), gexp[c] != 0 ? DW'(6) : DW'(5));
      tick();
      chk("rr_rsp", DW'({rsp0_vld, rsp1_vld}), gexp[c] != 0 ? DW'(2'b01) : DW'(2'b10));
      chk("rr_data", rsp_data, gexp[c] != 0 ? DW'(0) : MASK);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    #1 chk("rr_off", DW'({req0_rdy, req1_rdy}), '0);
    tick();
    chk("rr_rsp_off", DW'({rsp0_vld, rsp1_vld}), '0);

    // init_req together with a granted read: the read still answers
    req0_vld = 1'b1; req0_addr = 14'h0005; init_req = 1'b1;
    #1 chk("ir_rdy", DW'(req0_rdy), DW'(1));
    tick();
    req0_vld = 1'b0; init_req = 1'b0;
    chk("ir_rsp", DW'({rsp0_vld, rsp1_vld, init_done}), DW'(3'b100));
    chk("ir_data", rsp_data, MASK);
    fill();
    chk("done2", DW'(init_done), DW'(1));
    req0_vld = 1'b1;
    tick();
    req0_vld = 1'b0;
    chk("clr_rsp", DW'(rsp0_vld), DW'(1));
    chk("clr_data", rsp_data, '0);

    // Reset drops a pending response immediately
    req1_vld = 1'b1; req1_addr = 14'h0006;
    tick();
    req1_vld = 1'b0;
    chk("pend_rsp", DW'(rsp1_vld), DW'(1));
    rst = 1'b1;
    #1 chk_reset("droprst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
